// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   state_e          FSM state encodings (IDLE, LOAD, SEND, FINISH)
//   DEF_FRAME_BYTES  default bytes per frame
//   DEF_TIMEOUT      default byte-done timeout, in cycles
//   TMO_W            width of the timeout counter
//   idx_w()          index width helper that never returns zero
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int DEF_FRAME_BYTES = 5;
  localparam int DEF_TIMEOUT     = 65535;
  localparam int TMO_W           = 16;

  // A 1-entry space still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin picker for the UART transmit arbiter.
// Purely combinational. The search starts at (last_owner+1) mod NUM_REQ and
// returns the first requesting client found.
// Ports:
//   req         per-client request levels
//   last_owner  index of the most recently served client
//   win_oh      one-hot winner; zero when no request is pending
//   win_idx     binary index of the winner
//   win_any     high when any request is pending
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  int               cand_i;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    cand_i  = 0;
    cand    = '0;
    // last_owner is always below NUM_REQ, so one subtraction is enough to wrap.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = int'(last_owner) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = IDX_W'(cand_i);
      if (!win_any && req[cand]) begin
        win_any      = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ clients for a single byte-wide UART transmitter.
// The winning client's whole frame is captured at grant time. The frame is
// then streamed byte by byte, LSB byte first, with one LOAD cycle per byte.
// A byte whose done pulse does not arrive within TIMEOUT cycles aborts the
// frame.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req             per-client request levels
//   frame_data      client i's frame is at [i*FRAME_BYTES*8 +: FRAME_BYTES*8]
//   grant           one-hot pulse: client's frame has been captured
//   done            one-hot pulse: client's frame has been fully transmitted
//   err             one-hot pulse: client's frame was aborted on timeout
//   uart_send       byte-transmit request level
//   send_data       byte presented to the transmitter
//   uart_send_done  byte-finished pulse from the transmitter
//   busy            high whenever the FSM is not idle
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FRAME_BYTES*8-1:0] frame_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              err,
  output logic                            uart_send,
  output logic [7:0]                      send_data,
  input  logic                            uart_send_done,
  output logic                            busy
);

  localparam int FW     = FRAME_BYTES * 8;
  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int BIDX_W = idx_w(FRAME_BYTES);

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(FRAME_BYTES - 1);
  // The counter is compared before it increments, so the abort fires on the
  // edge where it would have reached TIMEOUT.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [IDX_W-1:0]    last_owner, last_owner_nxt;
  logic [FW-1:0]       frame, frame_nxt;
  logic [BIDX_W-1:0]   byte_idx, byte_idx_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic [7:0]          send_data_nxt;
  logic [NUM_REQ-1:0]  grant_nxt, done_nxt, err_nxt;
  logic [NUM_REQ-1:0]  owner_oh;

  logic [NUM_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_owner (last_owner),
    .win_oh     (win_oh),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign owner_oh  = NUM_REQ'(1) << owner;
  assign uart_send = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    frame_nxt      = frame;
    byte_idx_nxt   = byte_idx;
    tmo_cnt_nxt    = tmo_cnt;
    send_data_nxt  = send_data;
    grant_nxt      = '0;
    done_nxt       = '0;
    err_nxt        = '0;

    case (state)
      ST_IDLE: begin
        if (win_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) frame_nxt = frame_data[i*FW +: FW];
          end
          owner_nxt    = win_idx;
          grant_nxt    = win_oh;
          byte_idx_nxt = '0;
          state_nxt    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        for (int b = 0; b < FRAME_BYTES; b++) begin
          if (byte_idx == BIDX_W'(b)) send_data_nxt = frame[b*8 +: 8];
        end
        tmo_cnt_nxt = '0;
        state_nxt   = ST_SEND;
      end

      ST_SEND: begin
        // A done pulse on the same edge as the timeout still counts as success.
        if (uart_send_done) begin
          send_data_nxt = '0;
          if (byte_idx == LAST_BYTE) begin
            done_nxt  = owner_oh;
            state_nxt = ST_FINISH;
          end else begin
            byte_idx_nxt = byte_idx + BIDX_W'(1);
            state_nxt    = ST_LOAD;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt        = owner_oh;
          last_owner_nxt = owner;
          send_data_nxt  = '0;
          state_nxt      = ST_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end

      ST_FINISH: begin
        last_owner_nxt = owner;
        state_nxt      = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      frame      <= '0;
      byte_idx   <= '0;
      tmo_cnt    <= '0;
      send_data  <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      frame      <= frame_nxt;
      byte_idx   <= byte_idx_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      send_data  <= send_data_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting clients.
REQ-002 Parameter FRAME_BYTES, default 5: bytes per frame.
REQ-003 Parameter TIMEOUT, default 65535: maximum cycles to wait for a byte-done; 16-bit.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-client request level; client i wants to send a frame.
REQ-007 frame_data  in  NUM_REQ*FRAME_BYTES*8  client i's frame at bits [i*FRAME_BYTES*8 +: FRAME_BYTES*8].
REQ-008 grant  out  NUM_REQ  one-hot, one-cycle pulse: client i's frame has been captured.
REQ-009 done  out  NUM_REQ  one-hot, one-cycle pulse: client i's frame has been fully transmitted.
REQ-010 err  out  NUM_REQ  one-hot, one-cycle pulse: client i's frame was aborted on timeout.
REQ-011 uart_send  out  1  byte-transmit request level to the UART transmitter.
REQ-012 send_data  out  8  byte presented to the transmitter.
REQ-013 uart_send_done  in  1  single-cycle pulse from the transmitter: byte finished.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SEND and FINISH, all registered.
REQ-016 IDLE, any req bit high: select a winner round-robin starting at (last_owner+1) mod NUM_REQ; capture its frame into a FRAME_BYTES*8 register; byte_idx=0; pulse grant[winner] in the next cycle; go to LOAD.
REQ-017 IDLE, no req: remain in IDLE; all outputs 0.
REQ-018 LOAD: register send_data = captured byte[byte_idx], where byte 0 = bits [7:0] (LSB byte first); clear the timeout counter; go to SEND.
REQ-019 SEND: hold uart_send=1 and send_data stable. On sampling uart_send_done=1, drop uart_send in the following cycle and act on byte_idx:
  - byte_idx==FRAME_BYTES-1: go to FINISH;
  - otherwise: increment byte_idx and go to LOAD.
REQ-020 SEND: the timeout counter increments every cycle. When it reaches TIMEOUT with no uart_send_done: pulse err[owner], drop uart_send, update last_owner, go to IDLE; done is not pulsed.
REQ-021 FINISH: pulse done[owner] for one cycle; last_owner=owner; go to IDLE.
REQ-022 Latency: req sampled at edge 0 gives grant high in cycle 1, and uart_send=1 with byte 0 in cycle 2. Minimum per-byte overhead is 1 LOAD cycle.
REQ-023 uart_send_done outside SEND SHALL be ignored.
REQ-024 A req drop after grant SHALL NOT abort the frame; frame_data changes after capture SHALL NOT affect the bytes sent.
REQ-025 A client holding req continuously SHALL be granted at most once per round when other clients request; with a single requester, frames run back-to-back via IDLE (one cycle gap).
REQ-026 Simultaneous requests: the lowest index at or after last_owner+1 (modulo NUM_REQ) wins.
REQ-027 grant, done and err SHALL never be high in the same cycle, and each SHALL have at most one bit set.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, last_owner=NUM_REQ-1 (client 0 wins first), byte_idx=0, timeout counter=0, grant=done=err=0, uart_send=0, send_data=0, busy=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done or err pulse.

Structure
REQ-030 The shared UART header SHALL hold the state encodings and the default FRAME_BYTES (5) and TIMEOUT values.
REQ-031 The round-robin picker SHALL be a separate sub-module, rr_arbiter: combinational one-hot winner from req and last_owner.

Verification
REQ-032 Single client 0, frame 0x4433221100, uart_send_done 3 cycles after each uart_send rise:
  - send_data sequence 0x00, 0x11, 0x22, 0x33, 0x44;
  - exactly 5 uart_send pulses;
  - done[0] pulses once.
REQ-033 req=4'b1111 held constantly: grant order 0,1,2,3,0; each done matches its grant owner.
REQ-034 Client 2 drops req the cycle after grant[2]: all 5 bytes are still sent, and done[2] pulses.
REQ-035 uart_send_done withheld, TIMEOUT=16: err[owner] pulses exactly 16 cycles after SEND entry, then uart_send=0 and busy=0.
REQ-036 rst low during byte 3: all outputs 0 immediately. After release with req=4'b0011, client 0 is granted first.
REQ-037 Spurious uart_send_done pulses in IDLE and LOAD: no state change, no byte skipped.
